sync_fifo_param: RTL and testbench

- Parametrised single-clock FIFO; next generation of the team's fixed 8-bit FIFO.
- Adds configurable width and depth, occupancy count, programmable almost-full/almost-empty flags, read-data valid, overflow/underflow pulses, and well-defined simultaneous read/write.
- Sits between producer and consumer logic in the same clock domain.

---
 rtl/sync_fifo_param.sv | 145 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Purpose  : Parametrised single-clock FIFO with occupancy count, programmable
//            almost-full / almost-empty flags, read-data valid and
//            overflow / underflow pulses.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH     data word width in bits (>= 1)
//   DEPTH     number of entries (>= 2, any integer)
//   AF_LEVEL  almost_full  asserts when count >= AF_LEVEL
//   AE_LEVEL  almost_empty asserts when count <= AE_LEVEL
// Ports
//   clk           clock, rising edge
//   reset         asynchronous, active-high reset
//   wr / w_data   write request and write word
//   rd            read request (acknowledge in fall-through mode)
//   r_data        read word
//   r_valid       r_data holds a valid popped word
//   full, empty, almost_full, almost_empty   occupancy flags
//   count         current occupancy
//   overflow      one-cycle pulse after a rejected write
//   underflow     one-cycle pulse after a rejected read
// Build option
//   SYNC_FIFO_FWFT_EN  defined: first-word fall-through, the head word is
//                      shown combinationally and r_valid = !empty.
//                      undefined: registered read, one cycle latency.
// ============================================================================
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr,
    input  logic [WIDTH-1:0]           w_data,
    input  logic                       rd,
    output logic [WIDTH-1:0]           r_data,
    output logic                       r_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int                 c_ptr_w    = $clog2(DEPTH);
    localparam int                 c_cnt_w    = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_rd_accept;
    logic               w_wr_accept;

    // DEPTH need not be a power of two, so wrap explicitly at DEPTH-1.
    function automatic logic [c_ptr_w-1:0] ptr_next(input logic [c_ptr_w-1:0] ptr);
        return (ptr == c_ptr_last) ? '0 : ptr + c_ptr_w'(1);
    endfunction

    // A write into a full FIFO is still accepted when a read frees a slot
    // on the same edge.
    assign w_rd_accept = rd && !empty;
    assign w_wr_accept = wr && (!full || w_rd_accept);

    // Flags decode the registered count, so they reflect post-edge state.
    assign empty        = (r_count == '0);
    assign full         = (r_count == c_cnt_full);
    assign almost_full  = (int'(r_count) >= AF_LEVEL);
    assign almost_empty = (int'(r_count) <= AE_LEVEL);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wptr] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wptr <= ptr_next(r_wptr);
            end
            if (w_rd_accept) begin
                r_rptr <= ptr_next(r_rptr);
            end
            case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            r_overflow  <= wr && !w_wr_accept;
            r_underflow <= rd && !w_rd_accept;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Fall-through: the head word is always presented; rd only pops it.
    assign r_data  = r_mem[r_rptr];
    assign r_valid = !empty;
`else
    logic [WIDTH-1:0] r_rdata;
    logic             r_rvalid;

    // Registered read: data and valid appear one cycle after the request;
    // r_data holds its last value when no read is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd_accept;
            if (w_rd_accept) begin
                r_rdata <= r_mem[r_rptr];
            end
        end
    end

    assign r_data  = r_rdata;
    assign r_valid = r_rvalid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Purpose  : Self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=8,
//            AF_LEVEL=6, AE_LEVEL=2). A queue-based model tracks the FIFO
//            contents; every expectation is derived from it or from
//            constants. Define SYNC_FIFO_FWFT_EN to exercise fall-through.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int c_depth = 8;
    localparam int c_af    = 6;
    localparam int c_ae    = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       rd = 1'b0;
    logic [7:0] r_data;
    logic       r_valid, full, empty, almost_full, almost_empty;
    logic [3:0] count;
    logic       overflow, underflow;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state
    logic [7:0] m_q[$];
    logic [7:0] m_rdata;
    logic       m_valid, m_ovf, m_udf;

    sync_fifo_param #(
        .WIDTH    (8),
        .DEPTH    (c_depth),
        .AF_LEVEL (c_af),
        .AE_LEVEL (c_ae)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .w_data       (w_data),
        .rd           (rd),
        .r_data       (r_data),
        .r_valid      (r_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Packed view of every DUT output. In fall-through mode r_data is
    // meaningless while the FIFO is empty, so it is masked there.
    function automatic logic [18:0] obs();
        logic [7:0] d;
        d = r_data;
`ifdef SYNC_FIFO_FWFT_EN
        if (m_q.size() == 0) d = 8'h00;
`endif
        return {r_valid, d, full, empty, almost_full, almost_empty, count, overflow, underflow};
    endfunction

    function automatic logic [18:0] expv();
        int         n;
        logic       ev;
        logic [7:0] ed;
        n = m_q.size();
`ifdef SYNC_FIFO_FWFT_EN
        ev = (n != 0);
        ed = (n != 0) ? m_q[0] : 8'h00;
`else
        ev = m_valid;
        ed = m_rdata;
`endif
        return {ev, ed, n == c_depth, n == 0, n >= c_af, n <= c_ae, 4'(n), m_ovf, m_udf};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_rdata = 8'h00;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    // Drive one clock cycle of requests and advance the model. Called at
    // posedge+1, returns at the following posedge+1.
    task automatic step(input logic w, input logic [7:0] d, input logic r);
        bit rd_acc, wr_acc;
        wr     = w;
        w_data = d;
        rd     = r;
        rd_acc = r && (m_q.size() != 0);
        wr_acc = w && ((m_q.size() < c_depth) || rd_acc);
        @(posedge clk);
        #1;
        if (rd_acc) m_rdata = m_q.pop_front();
        m_valid = rd_acc;
        if (wr_acc) m_q.push_back(d);
        m_ovf = w && !wr_acc;
        m_udf = r && !rd_acc;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        model_reset();
        tests_run++;
        if (obs() !== expv()) begin
            tests_failed++;
            $display("FAIL reset_held: got %h expected %h", obs(), expv());
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if ({empty, full, almost_empty, almost_full, count, r_valid} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_release: got e%b f%b ae%b af%b c%0d v%b", empty, full, almost_empty, almost_full, count, r_valid);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(i + 1), 1'b0);
            tests_run++;
            if (obs() !== expv()) begin
                tests_failed++;
                $display("FAIL fill[%0d]: got %h expected %h", i, obs(), expv());
            end
        end
        tests_run++;
        if (full !== 1'b1 || count !== 4'd8) begin
            tests_failed++;
            $display("FAIL fill_full: got full=%b count=%0d expected full=1 count=8", full, count);
        end
    endtask

    task automatic test_overflow();
        step(1'b1, 8'h09, 1'b0);
        tests_run++;
        if (obs() !== expv()) begin
            tests_failed++;
            $display("FAIL overflow_1: got %h expected %h", obs(), expv());
        end
        step(1'b1, 8'h0A, 1'b0);
        tests_run++;
        if (obs() !== expv()) begin
            tests_failed++;
            $display("FAIL overflow_2: got %h expected %h", obs(), expv());
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1);
            tests_run++;
            if (obs() !== expv()) begin
                tests_failed++;
                $display("FAIL drain[%0d]: got %h expected %h", i, obs(), expv());
            end
`ifndef SYNC_FIFO_FWFT_EN
            tests_run++;
            if (r_valid !== 1'b1 || r_data !== 8'(i + 1)) begin
                tests_failed++;
                $display("FAIL drain_data[%0d]: got v=%b d=%h expected v=1 d=%h", i, r_valid, r_data, 8'(i + 1));
            end
`endif
        end
    endtask

    task automatic test_underflow_wrap();
        logic [7:0] d;
        step(1'b0, 8'h00, 1'b1);
        tests_run++;
        if (obs() !== expv() || underflow !== 1'b1 || r_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL underflow: got %h expected %h", obs(), expv());
        end
        step(1'b0, 8'h00, 1'b0);
        tests_run++;
        if (obs() !== expv()) begin
            tests_failed++;
            $display("FAIL underflow_end: got %h expected %h", obs(), expv());
        end
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            step(1'b1, d, 1'b0);
            step(1'b0, 8'h00, 1'b1);
            tests_run++;
            if (obs() !== expv()) begin
                tests_failed++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'h55, 1'b1);
        tests_run++;
        if (obs() !== expv() || count !== 4'd8 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_full: got %h expected %h", obs(), expv());
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1);
            tests_run++;
            if (obs() !== expv()) begin
                tests_failed++;
                $display("FAIL simul_drain[%0d]: got %h expected %h", i, obs(), expv());
            end
        end
        step(1'b1, 8'h55, 1'b1);
        tests_run++;
        if (obs() !== expv() || count !== 4'd1 || underflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL simul_empty: got %h expected %h", obs(), expv());
        end
        step(1'b0, 8'h00, 1'b1);
        tests_run++;
        if (obs() !== expv()) begin
            tests_failed++;
            $display("FAIL simul_read55: got %h expected %h", obs(), expv());
        end
`ifndef SYNC_FIFO_FWFT_EN
        tests_run++;
        if (r_data !== 8'h55 || r_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL simul_data55: got v=%b d=%h expected v=1 d=55", r_valid, r_data);
        end
`endif
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'($urandom), 1'b0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        tests_run++;
        if (empty !== 1'b1 || count !== 4'd0 || r_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: got e=%b c=%0d v=%b expected e=1 c=0 v=0", empty, count, r_valid);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tests_run++;
        if (obs() !== expv()) begin
            tests_failed++;
            $display("FAIL reset_mid_held: got %h expected %h", obs(), expv());
        end
        step(1'b1, 8'h3C, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        tests_run++;
        if (obs() !== expv()) begin
            tests_failed++;
            $display("FAIL reset_mid_readback: got %h expected %h", obs(), expv());
        end
    endtask

    task automatic test_random();
        int pw, pr;
        for (int i = 0; i < 400; i++) begin
            pw = (i % 100 < 50) ? 75 : 30;
            pr = (i % 100 < 50) ? 30 : 75;
            step(1'($urandom_range(0, 99) < pw), 8'($urandom), 1'($urandom_range(0, 99) < pr));
            tests_run++;
            if (obs() !== expv()) begin
                tests_failed++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs(), expv());
            end
        end
    endtask

`ifdef SYNC_FIFO_FWFT_EN
    task automatic test_fwft();
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hA2, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        tests_run++;
        if (r_data !== 8'hA1 || r_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL fwft_head: got v=%b d=%h expected v=1 d=a1", r_valid, r_data);
        end
        step(1'b0, 8'h00, 1'b1);
        tests_run++;
        if (r_data !== 8'hA2 || r_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL fwft_next: got v=%b d=%h expected v=1 d=a2", r_valid, r_data);
        end
        step(1'b0, 8'h00, 1'b1);
        tests_run++;
        if (empty !== 1'b1 || r_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL fwft_empty: got e=%b v=%b expected e=1 v=0", empty, r_valid);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_overflow();
        test_underflow_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
`ifdef SYNC_FIFO_FWFT_EN
        test_fwft();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
